// File: rtl/bg_index_gen.sv
// bg_index_gen
//   Per-pixel background colour-index generator. For every active pixel it
//   produces a 4-bit palette code: 0-7 select one of eight horizontal desert
//   bands, 8 selects sky (palette default). The bands scroll vertically by a
//   frame-synchronous offset, so a frame is never drawn with two offsets.
//
// Ports
//   Clk          pixel clock
//   Reset        synchronous, active-high
//   frame_start  1-cycle pulse on the first cycle of each frame
//   pix_valid    DrawX/DrawY valid and inside the active area
//   DrawX        pixel column, carried through to bg_x
//   DrawY        pixel row, 0..479
//   scroll_en    1 = scroll, 0 = hold offset (sampled on frame_start)
//   scroll_dir   0 = bands move up (+STEP), 1 = down (-STEP) (sampled on frame_start)
//   bgcolor      colour index to the palette stage
//   bg_valid     bgcolor valid, pix_valid delayed 2 cycles, gated by state
//   bg_x         DrawX delayed 2 cycles, aligned with bgcolor
//   offset       current scroll offset, BAND_SHIFT+3 bits
module bg_index_gen #(
  parameter int BAND_SHIFT = 6,
  parameter int HORIZON    = 96,
  parameter int FRAME_DIV  = 2,
  parameter int STEP       = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  scroll_en,
  input  logic                  scroll_dir,
  output logic [3:0]            bgcolor,
  output logic                  bg_valid,
  output logic [9:0]            bg_x,
  output logic [BAND_SHIFT+2:0] offset
);

  localparam int W  = BAND_SHIFT + 3;
  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [W-1:0]  STEP_W    = W'(STEP);
  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_DIV - 1);
  localparam logic [9:0]    HORIZON_Y = 10'(HORIZON);
  localparam logic [3:0]    SKY_CODE  = 4'h8;

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Offset arithmetic wraps silently modulo 2^W in both directions.
  function automatic logic [W-1:0] step_offset(input logic [W-1:0] cur,
                                               input logic         dir);
    return dir ? (cur - STEP_W) : (cur + STEP_W);
  endfunction

  // Band number is the top three bits of the scrolled row.
  function automatic logic [3:0] band_code(input logic         sky,
                                           input logic [W-1:0] sum);
    return sky ? SKY_CODE : {1'b0, sum[W-1:BAND_SHIFT]};
  endfunction

  logic [0:0]    state;
  logic [CW-1:0] frame_cnt;
  logic          en_lat;
  logic          dir_lat;
  logic [W-1:0]  offset_q;

  // Control: state, latches and offset only change on frame_start, and the
  // step decision uses the latch values from the previous frame_start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_SYNC;
      frame_cnt <= '0;
      en_lat    <= 1'b0;
      dir_lat   <= 1'b0;
      offset_q  <= '0;
    end else if (frame_start) begin
      en_lat  <= scroll_en;
      dir_lat <= scroll_dir;
      if (state == ST_SYNC) begin
        state <= ST_RUN;
      end else if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        if (en_lat) offset_q <= step_offset(offset_q, dir_lat);
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign offset = offset_q;

  logic         sky_p1;
  logic [W-1:0] sum_p1;
  logic [9:0]   x_p1;
  logic         vld_p1;

  // Stage 1: sky test and scrolled row, using the offset before any update
  // happening this same cycle.
  always_ff @(posedge Clk) begin
    sky_p1 <= (DrawY < HORIZON_Y);
    sum_p1 <= DrawY[W-1:0] + offset_q;
    x_p1   <= DrawX;
  end

  always_ff @(posedge Clk) begin
    if (Reset) vld_p1 <= 1'b0;
    else       vld_p1 <= pix_valid & (state == ST_RUN);
  end

  // Stage 2: colour code; blank cycles read as the sky default.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bg_valid <= 1'b0;
      bgcolor  <= SKY_CODE;
      bg_x     <= '0;
    end else begin
      bg_valid <= vld_p1;
      bgcolor  <= vld_p1 ? band_code(sky_p1, sum_p1) : SKY_CODE;
      bg_x     <= x_p1;
    end
  end

endmodule

// File: tb/tb_bg_index_gen.sv
module tb_bg_index_gen;

  localparam int BS     = 6;
  localparam int HOR    = 96;
  localparam int FD     = 2;
  localparam int ST     = 1;
  localparam int PERIOD = 8 << BS;
  localparam int BAND_H = 1 << BS;

  logic       Clk;
  logic       Reset;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       scroll_en;
  logic       scroll_dir;
  logic [3:0] bgcolor;
  logic       bg_valid;
  logic [9:0] bg_x;
  logic [BS+2:0] offset;

  bg_index_gen #(.BAND_SHIFT(BS), .HORIZON(HOR), .FRAME_DIV(FD), .STEP(ST)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .scroll_en(scroll_en), .scroll_dir(scroll_dir),
    .bgcolor(bgcolor), .bg_valid(bg_valid), .bg_x(bg_x), .offset(offset)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int color;
    int x;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int  npass = 0;
  int  ntot  = 0;
  int  cyc   = 0;
  bit  mon_en = 1'b0;
  bit  armed  = 1'b0;

  // Reference model: frame-level scroll behaviour with plain integers.
  bit  m_run = 1'b0;
  int  m_off = 0;
  int  m_frames = 0;
  bit  m_en = 1'b0;
  bit  m_dir = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic int exp_color(int y);
    if (y < HOR) return 8;
    return ((y + m_off) % PERIOD) / BAND_H;
  endfunction

  task automatic step(input bit fs, input bit pv, input int x, input int y,
                      input bit en, input bit dir, input bit rst);
    @(posedge Clk);
    #1;
    if (armed) begin
      mon_en = 1'b1;
      armed  = 1'b0;
    end
    if (mon_en) chk("offset", int'(offset), m_off);
    cyc++;
    Reset       = rst;
    frame_start = fs;
    pix_valid   = pv;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    scroll_en   = en;
    scroll_dir  = dir;
    if (rst) begin
      // the pixel issued last cycle is still in flight when reset lands
      if (q.size() > 0 && q[$].cyc == cyc - 1) q.delete(q.size() - 1);
      m_run = 1'b0; m_off = 0; m_frames = 0; m_en = 1'b0; m_dir = 1'b0;
      armed = 1'b1;
    end else begin
      if (m_run && pv) q.push_back('{exp_color(y), x, cyc});
      if (fs) begin
        if (!m_run) begin
          m_run = 1'b1;
        end else begin
          m_frames++;
          if (m_frames % FD == 0 && m_en)
            m_off = m_dir ? (m_off - ST + PERIOD) % PERIOD : (m_off + ST) % PERIOD;
        end
        m_en  = en;
        m_dir = dir;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic frame(input bit en, input bit dir, input int npix, input bit toggle);
    step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 639)),
         int'($urandom_range(0, 479)), en, dir, 1'b0);
    for (int i = 0; i < npix; i++) begin
      bit ee;
      ee = (toggle && i >= npix / 2) ? !en : en;
      step(1'b0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 639)),
           int'($urandom_range(0, 479)), ee, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid pixel.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (bg_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bgcolor", int'(bgcolor), e.color);
          chk("bg_x", int'(bg_x), e.x);
        end
      end else begin
        chk("blank_bgcolor", int'(bgcolor), 8);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int exp_off[5];
    exp_off = '{0, 0, 1, 1, 2};
    Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
    DrawX = '0; DrawY = '0; scroll_en = 1'b0; scroll_dir = 1'b0;

    // T1: valid pixels before any frame_start stay blank
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 100 + i, 200, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t1_valid", int'(bg_valid), 0);

    // T2: band boundaries with offset 0
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10, 96, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 11, 127, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12, 128, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 13, 479, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 14, 95, 1'b0, 1'b0, 1'b0);
    idle(3);

    // T3: up-scroll, one step every second frame
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk("t3_offset_seq", int'(offset), exp_off[i]);
    end
    while (m_off < 66) begin
      step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 5, 128, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
           1'b1, 1'b0, 1'b0);
    end
    idle(2);

    // T4: down-scroll wraps from 0
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("t4_offset_wrap", int'(offset), 511);
    step(1'b0, 1'b1, 33, 100, 1'b1, 1'b1, 1'b0);
    idle(3);

    // T5: disabling mid-frame still takes the pending step, then stops
    do_reset();
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7, 300, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8, 300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("t5_step_taken", int'(offset), 1);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("t5_step_stopped", int'(offset), 1);

    // T6: reset mid-frame with pixels in flight
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 50 + i, 300, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 60, 300, 1'b1, 1'b0, 1'b1);
    idle(1);
    chk("t6_valid_after_reset", int'(bg_valid), 0);
    chk("t6_offset_after_reset", int'(offset), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 70 + i, 250, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("t6_still_blank", int'(bg_valid), 0);

    // Randomized frames with occasional resets
    for (int f = 0; f < 250; f++) begin
      if ($urandom_range(0, 29) == 0) do_reset();
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)));
    end

    idle(4);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
